// File: rtl/rs_corr_reader_if.sv
// rs_corr_reader_if
// Bundles the three input streams and the output stream of rs_corr_reader.
//   Status token : dec_valid, dec_fail (to reader), dec_ready (from reader)
//   Delay FIFO   : fifo_empty, fifo_data (to reader), fifo_pull (from reader)
//   Error stream : err_valid, err_val (to reader), err_ready (from reader)
//   Output       : m_valid, m_data, m_last, m_fail, m_nerr (from reader), m_ready (to reader)
// The master modport is the reader's view; slave is the environment's view.
interface rs_corr_reader_if #(
    parameter int DATA_WIDTH = 10,
    parameter int NERR_WIDTH = 5
);
    logic                  dec_valid;
    logic                  dec_fail;
    logic                  dec_ready;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_pull;
    logic                  err_valid;
    logic [DATA_WIDTH-1:0] err_val;
    logic                  err_ready;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_fail;
    logic [NERR_WIDTH-1:0] m_nerr;
    logic                  m_ready;

    modport master (
        input  dec_valid, dec_fail, fifo_empty, fifo_data, err_valid, err_val, m_ready,
        output dec_ready, fifo_pull, err_ready, m_valid, m_data, m_last, m_fail, m_nerr
    );

    modport slave (
        output dec_valid, dec_fail, fifo_empty, fifo_data, err_valid, err_val, m_ready,
        input  dec_ready, fifo_pull, err_ready, m_valid, m_data, m_last, m_fail, m_nerr
    );
endinterface

// File: rtl/rs_corr_reader.sv
// rs_corr_reader
// Consumer end of the decoder's codeword delay FIFO. Accepts one decode-status
// token per codeword, then pulls N_SYM symbols from the show-ahead FIFO in
// lock-step with the Chien/Forney error-magnitude stream, XOR-corrects them and
// emits them on a registered valid/ready output with last/fail/nerr sideband.
// Ports:
//   aclk    - clock
//   aresetn - asynchronous active-low reset
//   bus     - rs_corr_reader_if.master (token, FIFO, error and output streams)
module rs_corr_reader #(
    parameter int DATA_WIDTH = 10,
    parameter int N_SYM      = 544,
    parameter int CNT_WIDTH  = 10,
    parameter int NERR_WIDTH = 5
) (
    input  logic             aclk,
    input  logic             aresetn,
    rs_corr_reader_if.master bus
);
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(N_SYM - 1);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  sym_cnt_q, sym_cnt_d;
    logic [NERR_WIDTH-1:0] nerr_cnt_q, nerr_cnt_d;
    logic                  fail_q, fail_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;
    logic                  m_fail_q, m_fail_d;
    logic [NERR_WIDTH-1:0] m_nerr_q, m_nerr_d;

    logic out_free;
    logic fire;
    logic last_sym;
    logic tok_acc;
    logic sym_err;
    logic dec_ready_c;

    // Counter saturates at all-ones so a heavily corrupted word cannot wrap to a small count.
    function automatic logic [NERR_WIDTH-1:0] sat_inc(input logic [NERR_WIDTH-1:0] v);
        return (&v) ? v : v + NERR_WIDTH'(1);
    endfunction

    assign out_free = !m_valid_q || bus.m_ready;
    assign fire     = (state_q == STREAM) && !bus.fifo_empty && bus.err_valid && out_free;
    assign last_sym = (sym_cnt_q == LAST_IDX);
    assign tok_acc  = (state_q == IDLE) && bus.dec_valid;
    // Failed words pass through raw, so their error magnitudes never count as corrections.
    assign sym_err  = !fail_q && (bus.err_val != '0);

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.dec_valid) state_d = STREAM;
            STREAM:  if (fire && last_sym) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; FIFO and error stream always advance together on fire.
    always_comb begin
        dec_ready_c = (state_q == IDLE);
    end

    assign bus.dec_ready = dec_ready_c;
    assign bus.fifo_pull = fire;
    assign bus.err_ready = fire;

    always_comb begin
        sym_cnt_d  = sym_cnt_q;
        nerr_cnt_d = nerr_cnt_q;
        fail_d     = fail_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        m_fail_d   = m_fail_q;
        m_nerr_d   = m_nerr_q;

        if (tok_acc) begin
            fail_d     = bus.dec_fail;
            sym_cnt_d  = '0;
            nerr_cnt_d = '0;
        end

        if (fire) begin
            m_valid_d  = 1'b1;
            m_data_d   = bus.fifo_data ^ (fail_q ? '0 : bus.err_val);
            m_fail_d   = fail_q;
            m_last_d   = last_sym;
            sym_cnt_d  = last_sym ? '0 : sym_cnt_q + CNT_WIDTH'(1);
            nerr_cnt_d = sym_err ? sat_inc(nerr_cnt_q) : nerr_cnt_q;
            m_nerr_d   = last_sym ? nerr_cnt_d : '0;
        end else if (bus.m_ready) begin
            // Output taken with nothing new to replace it; sideband may keep stale values.
            m_valid_d = 1'b0;
        end
    end

    // Stage boundary: fire -> registered output (1-cycle latency)
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sym_cnt_q  <= '0;
            nerr_cnt_q <= '0;
            fail_q     <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
            m_fail_q   <= 1'b0;
            m_nerr_q   <= '0;
        end else begin
            sym_cnt_q  <= sym_cnt_d;
            nerr_cnt_q <= nerr_cnt_d;
            fail_q     <= fail_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            m_fail_q   <= m_fail_d;
            m_nerr_q   <= m_nerr_d;
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_last  = m_last_q;
    assign bus.m_fail  = m_fail_q;
    assign bus.m_nerr  = m_nerr_q;
endmodule

// File: tb/tb_rs_corr_reader.sv
module tb_rs_corr_reader;
    localparam int DW = 10;
    localparam int N  = 544;
    localparam int CW = 10;
    localparam int NW = 5;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    rs_corr_reader_if #(.DATA_WIDTH(DW), .NERR_WIDTH(NW)) bus ();

    rs_corr_reader #(
        .DATA_WIDTH(DW),
        .N_SYM     (N),
        .CNT_WIDTH (CW),
        .NERR_WIDTH(NW)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          fail;
        logic [NW-1:0] nerr;
    } exp_t;

    // Behavioural environment: FIFO contents, error stream, token queue, expected outputs.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] err_q[$];
    bit            tok_q[$];
    exp_t          exp_q[$];
    logic [DW-1:0] cw_sym[N];
    logic [DW-1:0] cw_err[N];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, outs = 0, pulls = 0, eready = 0, pulls_cw = 0, accepts = 0, out_in_cw = 0;
    bit in_cw = 0;
    int rdy_pct = 100;
    int empty_at = -1, empty_len = 0, errv_at = -1, errv_len = 0;
    int first_out_cyc[$];
    int last_out_cyc[$];
    bit stalled = 0;
    logic [31:0] hold_vec;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Queue one codeword: symbols to the FIFO, magnitudes to the error stream,
    // and the expected corrected output computed directly from the rules.
    task automatic push_cw(input bit fail);
        int   ne;
        exp_t e;
        ne = 0;
        for (int i = 0; i < N; i++) if (!fail && cw_err[i] != '0) ne++;
        if (ne > 31) ne = 31;
        for (int i = 0; i < N; i++) begin
            fifo_q.push_back(cw_sym[i]);
            err_q.push_back(cw_err[i]);
            e.data = fail ? cw_sym[i] : (cw_sym[i] ^ cw_err[i]);
            e.last = (i == N - 1);
            e.fail = fail;
            e.nerr = (i == N - 1) ? NW'(ne) : '0;
            exp_q.push_back(e);
        end
        tok_q.push_back(fail);
    endtask

    task automatic cycle();
        bit   pull, er, hs, acc, fe, ev;
        exp_t e;
        @(negedge aclk);
        fe = (fifo_q.size() == 0);
        ev = (err_q.size() != 0);
        if (in_cw && pulls_cw == empty_at && empty_len > 0) begin fe = 1; empty_len--; end
        if (in_cw && pulls_cw == errv_at && errv_len > 0) begin ev = 0; errv_len--; end
        bus.fifo_empty = fe;
        bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        bus.err_valid  = ev;
        bus.err_val    = (err_q.size() != 0) ? err_q[0] : '0;
        bus.dec_valid  = (tok_q.size() != 0);
        bus.dec_fail   = (tok_q.size() != 0) ? tok_q[0] : 1'b0;
        bus.m_ready    = ($urandom_range(99) < rdy_pct);
        #1;
        pull = bus.fifo_pull;
        er   = bus.err_ready;
        hs   = bus.m_valid && bus.m_ready;
        acc  = bus.dec_valid && bus.dec_ready;
        chk("pull_eq_err_ready", pull, er);
        if (pull) chk("pull_when_blocked", !fe && ev && (!bus.m_valid || bus.m_ready) && in_cw, 1);
        if (!in_cw) chk("idle_no_pull", pull, 0);
        chk("dec_ready", bus.dec_ready, !in_cw);
        if (stalled)
            chk("hold_stable", {bus.m_valid, bus.m_data, bus.m_last, bus.m_fail, bus.m_nerr}, hold_vec);
        if (hs) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("m_data", bus.m_data, e.data);
                chk("m_last", bus.m_last, e.last);
                chk("m_fail", bus.m_fail, e.fail);
                chk("m_nerr", bus.m_nerr, e.nerr);
            end
            if (out_in_cw == 0) first_out_cyc.push_back(cyc);
            out_in_cw++;
            if (bus.m_last) begin last_out_cyc.push_back(cyc); out_in_cw = 0; end
            outs++;
        end
        stalled  = bus.m_valid && !bus.m_ready;
        hold_vec = {14'd0, bus.m_valid, bus.m_data, bus.m_last, bus.m_fail, bus.m_nerr};
        @(posedge aclk);
        cyc++;
        if (pull && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            pulls++;
            pulls_cw++;
            if (pulls_cw == N) in_cw = 0;
        end
        if (er && err_q.size() != 0) begin void'(err_q.pop_front()); eready++; end
        if (acc) begin void'(tok_q.pop_front()); in_cw = 1; pulls_cw = 0; accepts++; end
    endtask

    task automatic run_outs(input int n, input int budget);
        int target;
        target = outs + n;
        while (outs < target && budget > 0) begin
            cycle();
            budget--;
        end
        chk("timeout_outputs", outs, target);
    endtask

    initial begin
        int p0, e0, a0;
        bus.dec_valid  = 0;
        bus.dec_fail   = 0;
        bus.fifo_empty = 1;
        bus.fifo_data  = '0;
        bus.err_valid  = 0;
        bus.err_val    = '0;
        bus.m_ready    = 1;

        // Reset values
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_last", bus.m_last, 0);
        chk("rst_m_fail", bus.m_fail, 0);
        chk("rst_m_nerr", bus.m_nerr, 0);
        chk("rst_dec_ready", bus.dec_ready, 1);
        chk("rst_fifo_pull", bus.fifo_pull, 0);
        chk("rst_err_ready", bus.err_ready, 0);
        @(negedge aclk);
        aresetn = 1;

        // Clean codeword, full throughput
        for (int i = 0; i < N; i++) begin cw_sym[i] = DW'(i); cw_err[i] = '0; end
        first_out_cyc.delete(); last_out_cyc.delete();
        p0 = pulls;
        push_cw(0);
        run_outs(N, 3000);
        chk("clean_pulls", pulls - p0, N);
        if (first_out_cyc.size() > 0 && last_out_cyc.size() > 0)
            chk("clean_throughput", last_out_cyc[0] - first_out_cyc[0], N - 1);
        else
            chk("clean_throughput_missing", 0, 1);

        // Corrected codeword: errors at first-boundary-ish and final index
        for (int i = 0; i < N; i++) begin cw_sym[i] = DW'($urandom); cw_err[i] = '0; end
        cw_err[5]   = 10'h3FF;
        cw_err[N-1] = 10'h001;
        push_cw(0);
        run_outs(N, 3000);

        // Uncorrectable codeword: raw pass-through, error stream still consumed
        for (int i = 0; i < N; i++) begin cw_sym[i] = DW'($urandom); cw_err[i] = 10'h155; end
        e0 = eready;
        push_cw(1);
        run_outs(N, 3000);
        chk("fail_err_ready_pulses", eready - e0, N);

        // Backpressure and source stalls; dense errors exercise nerr saturation
        rdy_pct   = 50;
        empty_at  = 100; empty_len = 3;
        errv_at   = 200; errv_len  = 2;
        for (int i = 0; i < N; i++) begin
            cw_sym[i] = DW'($urandom);
            cw_err[i] = ($urandom_range(1) == 1) ? DW'($urandom_range(1023, 1)) : '0;
        end
        p0 = pulls;
        push_cw(0);
        run_outs(N, 6000);
        chk("stall_pulls", pulls - p0, N);
        chk("stall_empty_done", empty_len, 0);
        chk("stall_errv_done", errv_len, 0);
        rdy_pct  = 100;
        empty_at = -1;
        errv_at  = -1;

        // Back-to-back codewords with the second token waiting during STREAM
        first_out_cyc.delete(); last_out_cyc.delete();
        a0 = accepts;
        for (int i = 0; i < N; i++) begin cw_sym[i] = DW'($urandom); cw_err[i] = (i % 7 == 0) ? DW'(i + 1) : '0; end
        push_cw(0);
        for (int i = 0; i < N; i++) begin cw_sym[i] = DW'($urandom); cw_err[i] = (i == 0) ? 10'h2AA : '0; end
        push_cw(0);
        run_outs(2 * N, 5000);
        chk("b2b_accepts", accepts - a0, 2);
        if (first_out_cyc.size() > 1 && last_out_cyc.size() > 0)
            chk("b2b_bubble_le1", (first_out_cyc[1] - last_out_cyc[0]) <= 2, 1);
        else
            chk("b2b_missing", 0, 1);

        // Reset mid-codeword
        for (int i = 0; i < N; i++) begin cw_sym[i] = DW'($urandom); cw_err[i] = '0; end
        push_cw(0);
        run_outs(300, 2000);
        @(negedge aclk);
        #2 aresetn = 0;
        #1;
        chk("midrst_m_valid", bus.m_valid, 0);
        chk("midrst_dec_ready", bus.dec_ready, 1);
        chk("midrst_fifo_pull", bus.fifo_pull, 0);
        fifo_q.delete(); err_q.delete(); tok_q.delete(); exp_q.delete();
        in_cw = 0; stalled = 0; out_in_cw = 0; pulls_cw = 0;
        @(posedge aclk);
        #1;
        chk("midrst_hold_m_valid", bus.m_valid, 0);
        @(negedge aclk);
        aresetn = 1;
        for (int i = 0; i < N; i++) begin cw_sym[i] = DW'($urandom); cw_err[i] = (i == 300) ? 10'h0F0 : '0; end
        push_cw(0);
        run_outs(N, 3000);

        repeat (3) cycle();
        chk("expected_drained", exp_q.size(), 0);
        chk("fifo_drained", fifo_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
